// File: rtl/btn_press_decoder.sv
// Classifies debounced button presses into short/long/double events plus a held level.
// Optional auto-repeat while a long press is held: compile with BTN_AUTO_REPEAT_EN.
module btn_press_decoder #(
  parameter int unsigned LONG_CYCLES   = 8,
  parameter int unsigned GAP_CYCLES    = 5,
  parameter int unsigned REPEAT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_db,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held,
  output logic repeat_pulse
);

  localparam int unsigned CNT_MAX = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("btn_press_decoder: cycle parameters must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_LONG   = 3'd2,
    S_GAP    = 3'd3,
    S_PRESS2 = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic          held_q, held_d;

  // Next-state, counter reload and event decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_db) begin
          state_d = S_PRESS1;
          cnt_d   = CW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESS1: begin
        if (!btn_db) begin
          state_d = S_GAP;
          cnt_d   = CW'(1);
        end else if (cnt_q == CW'(LONG_CYCLES - 1)) begin
          state_d = S_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_LONG: begin
        if (!btn_db) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_LONG;
        end
      end
      S_GAP: begin
        if (btn_db) begin
          state_d  = S_PRESS2;
          cnt_d    = '0;
          double_d = 1'b1;
        end else if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          short_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_PRESS2: begin
        if (!btn_db) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_PRESS2;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == S_PRESS1) || (state_d == S_LONG) || (state_d == S_PRESS2);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign held         = held_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          repeat_q, repeat_d;

  // Repeat period counter; only advances while a long press is still held.
  always_comb begin
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    if (state_q == S_PRESS1 && state_d == S_LONG) begin
      rcnt_d = '0;
    end else if (state_q == S_LONG && btn_db) begin
      if (rcnt_q == RW'(REPEAT_CYCLES - 1)) begin
        rcnt_d   = '0;
        repeat_d = 1'b1;
      end else begin
        rcnt_d   = rcnt_q + RW'(1);
      end
    end else begin
      rcnt_d = rcnt_q;
    end
  end

  // Repeat counter and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_press_decoder.sv
// Directed self-checking bench for btn_press_decoder (LONG=8, GAP=5, REPEAT=4).
// Expected repeat pulses follow the BTN_AUTO_REPEAT_EN macro of the build.
module tb_btn_press_decoder;

`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic btn_db;
  logic short_press, long_press, double_press, held, repeat_pulse;

  int total = 0;
  int bad   = 0;

  btn_press_decoder #(
    .LONG_CYCLES  (8),
    .GAP_CYCLES   (5),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_db      (btn_db),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held),
    .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", tag, obs, exp);
    end
  endtask

  // Drive one sample, let the edge take it, then check every output.
  task automatic cyc(input string tag, input int idx, input logic b,
                     input logic es, input logic el, input logic ed,
                     input logic eh, input logic er);
    string t;
    @(negedge clk);
    btn_db = b;
    @(posedge clk);
    #1;
    t = $sformatf("%s[%0d]", tag, idx);
    chk({t, ".short"},  short_press,  es);
    chk({t, ".long"},   long_press,   el);
    chk({t, ".double"}, double_press, ed);
    chk({t, ".held"},   held,         eh);
    chk({t, ".repeat"}, repeat_pulse, er);
  endtask

  initial begin
    reset  = 1'b0;
    btn_db = 1'b1;

    for (int i = 1; i <= 3; i++) cyc("reset", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc("rel_first", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) cyc("rel_low", i, 1'b0, i == 5, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 3; i++) cyc("short_hi", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) cyc("short_lo", i, 1'b0, i == 5, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 12; i++)
      cyc("long_hi", i, 1'b1, 1'b0, i == 8, 1'b0, 1'b1, REP_EN && (i == 12));
    for (int i = 1; i <= 6; i++) cyc("long_lo", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 3; i++) cyc("dbl_hi1", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 2; i++) cyc("dbl_lo",  i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) cyc("dbl_hi2", i, 1'b1, 1'b0, 1'b0, i == 1, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) cyc("dbl_end", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 3; i++) cyc("gap5_hi1", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) cyc("gap5_lo1", i, 1'b0, i == 5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) cyc("gap5_hi2", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) cyc("gap5_lo2", i, 1'b0, i == 5, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 3; i++) cyc("gap4_hi1", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) cyc("gap4_lo",  i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("gap4_hi2", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) cyc("gap4_end", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 20; i++)
      cyc("rep_hi", i, 1'b1, 1'b0, i == 8, 1'b0, 1'b1,
          REP_EN && (i == 12 || i == 16 || i == 20));
    for (int i = 1; i <= 6; i++) cyc("rep_lo", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in mid-gap must discard the pending short press.
    for (int i = 1; i <= 3; i++) cyc("rgap_hi", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 2; i++) cyc("rgap_lo", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("rgap_rst", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) cyc("rgap_after", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during a long hold clears held immediately.
    for (int i = 1; i <= 9; i++) cyc("rlong_hi", i, 1'b1, 1'b0, i == 8, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc("rlong_rst", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc("rlong_new", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) cyc("rlong_lo", i, 1'b0, i == 5, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_press_decoder.md
Name: btn_press_decoder

Overview:
- Sits directly downstream of btn_debounce and consumes its debounced, active-high button level.
- Classifies each press into one of three events: short press, long press or double press.
- Each event is a registered one-cycle pulse, for use by control logic such as mode select or menu stepping.
- Also reports a registered "held" level. An optional auto-repeat generates periodic pulses while a long press is held.

Parameters:
- LONG_CYCLES, 8: consecutive high samples that qualify a long press; legal range ≥2.
- GAP_CYCLES, 5: consecutive low samples after a short press that close the double-press window; legal range ≥2.
- REPEAT_CYCLES, 4: auto-repeat period in cycles; only used when BTN_AUTO_REPEAT_EN is defined; legal range ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- btn_db  input  1  debounced button level from btn_debounce; 1 = pressed; assumed already synchronous to clk.
- short_press  output  1  one-cycle pulse: single press released, with no second press inside the gap window.
- long_press  output  1  one-cycle pulse: press held for LONG_CYCLES samples.
- double_press  output  1  one-cycle pulse: second press began inside the gap window.
- held  output  1  high while the FSM is in PRESS1, LONG or PRESS2.
- repeat_pulse  output  1  auto-repeat pulse; constant 0 when the feature is compiled out.

Behaviour:
- Reset and counter:
  - Synchronous reset: reset==0 at a rising edge forces state=IDLE, cnt=0, rcnt=0 and every output to 0.
  - Reset takes priority over everything else, including mid-press or mid-gap operation; any partially detected event is discarded.
  - cnt is a localparam-sized counter wide enough for max(LONG_CYCLES, GAP_CYCLES). It never wraps: it is reloaded on every state change.
- Outputs: all registered. Event pulses last exactly one cycle, appear the cycle after the deciding sample, and at most one event pulse is high in any cycle.
- IDLE:
  - btn_db=1 -> PRESS1, cnt<=1.
  - Otherwise stay.
  - If btn_db is already 1 when reset releases, the first sample starts a new press.
- PRESS1:
  - btn_db=1 and cnt==LONG_CYCLES-1 -> LONG, long_press<=1, rcnt<=0.
  - btn_db=1 otherwise: cnt++.
  - btn_db=0 -> GAP, cnt<=1.
  - Net effect: long_press fires after the LONG_CYCLES-th consecutive high sample.
- LONG:
  - Stay while btn_db=1.
  - btn_db=0 -> IDLE.
  - Neither short_press nor double_press is issued for a press that reached LONG.
- GAP:
  - btn_db=0 and cnt==GAP_CYCLES-1 -> IDLE, short_press<=1. This fires after the GAP_CYCLES-th consecutive low sample.
  - btn_db=0 otherwise: cnt++.
  - btn_db=1 before that point -> PRESS2, double_press<=1.
- PRESS2:
  - Stay while btn_db=1; there is no long detection in this state.
  - btn_db=0 -> IDLE. No further pulse is issued.
- Boundary cases:
  - A press shorter than LONG_CYCLES followed by exactly GAP_CYCLES low samples yields short_press. A high on the next sample starts a fresh PRESS1, not a double press.
  - A high on low sample GAP_CYCLES-1 or earlier yields double_press.
- held:
  - held<=1 on any transition into PRESS1, LONG or PRESS2.
  - held<=0 on entry to IDLE or GAP.
  - held therefore lags btn_db by one cycle.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - In LONG with btn_db=1: if rcnt==REPEAT_CYCLES-1, then repeat_pulse<=1 and rcnt<=0; otherwise rcnt++.
  - First repeat fires after LONG_CYCLES+REPEAT_CYCLES high samples, then every REPEAT_CYCLES samples.
  - Release stops repeats immediately.
- Undefined: rcnt logic is absent and repeat_pulse is tied to 0. The port list is unchanged.

Test Plan (LONG_CYCLES=8, GAP_CYCLES=5, REPEAT_CYCLES=4):
- Reset: reset=0 for 3 cycles with btn_db=1 -> all outputs 0 throughout; after reset=1, held=1 one cycle after the first sampled high.
- Short press: btn_db high 3 cycles, then low -> single short_press pulse after the 5th low sample; long_press=0, double_press=0.
- Long press: btn_db high 12 cycles -> long_press pulse after the 8th high sample; held=1 for 12 cycles (lagging btn_db by one); no short_press after release.
- Double press: high 3, low 2, high 3 -> double_press pulse after the first high sample of the 2nd press; short_press never asserts.
- Gap boundary:
  - High 3, low 5, high 3 -> short_press after the 5th low; the second press is a fresh PRESS1, so it later yields a second short_press.
  - High 3, low 4, high -> double_press.
- Auto-repeat: high 20 cycles with the macro defined -> long_press after sample 8, repeat_pulse after samples 12, 16 and 20. Without the macro, repeat_pulse stays 0.
